// File: rtl/systolic_mm_nxn_if.sv
// Host-side bundle for the N x N systolic multiplier: start/acc_en request,
// packed row-major operand matrices A/B, result matrix C and busy/done status.
interface systolic_mm_nxn_if #(
  parameter int DATA_WIDTH = 8,
  parameter int N          = 2,
  parameter int ACC_WIDTH  = 24
);
  logic                         start;
  logic                         acc_en;
  logic [N*N*DATA_WIDTH-1:0]    A;
  logic [N*N*DATA_WIDTH-1:0]    B;
  logic [N*N*ACC_WIDTH-1:0]     C;
  logic                         busy;
  logic                         done;

  modport master (output start, acc_en, A, B, input C, busy, done);
  modport slave  (input start, acc_en, A, B, output C, busy, done);
endinterface

// File: rtl/systolic_mm_nxn.sv
// Output-stationary N x N systolic matrix multiplier: C = A x B or C += A x B,
// sequenced internally from a single start pulse to a single done pulse.
module systolic_mm_nxn #(
  parameter int DATA_WIDTH = 8,
  parameter int N          = 2,
  parameter int ACC_WIDTH  = 24,
  parameter int SIGNED     = 0
) (
  input  logic         clk,
  input  logic         rst,
  systolic_mm_nxn_if.slave bus
);

  localparam int STEPS = 3 * N - 2;
  localparam int KW    = $clog2(STEPS);
  localparam int LAST  = STEPS - 1;

  if (N < 2) begin : g_chk_n
    $error("systolic_mm_nxn: N must be at least 2");
  end
  if (ACC_WIDTH < 2 * DATA_WIDTH + $clog2(N)) begin : g_chk_acc
    $error("systolic_mm_nxn: ACC_WIDTH too small for full-precision sums");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FEED  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t                      state;
  logic [KW-1:0]               k;
  logic [N*N*DATA_WIDTH-1:0]   a_lat;
  logic [N*N*DATA_WIDTH-1:0]   b_lat;
  logic [N*N*ACC_WIDTH-1:0]    c_reg;
  logic                        busy_reg;
  logic                        done_reg;
  logic [DATA_WIDTH-1:0]       a_reg [N][N];
  logic [DATA_WIDTH-1:0]       b_reg [N][N];
  logic [ACC_WIDTH-1:0]        acc   [N][N];

  // a_bus[i][j] / b_bus[i][j] are the operands seen by PE(i,j); index 0 is the array edge
  logic [DATA_WIDTH-1:0]       a_bus [N][N+1];
  logic [DATA_WIDTH-1:0]       b_bus [N+1][N];
  logic [ACC_WIDTH-1:0]        prod  [N][N];

  // Full-precision product, sign- or zero-extended to the accumulator width
  function automatic logic [ACC_WIDTH-1:0] mul(input logic [DATA_WIDTH-1:0] x,
                                               input logic [DATA_WIDTH-1:0] y);
    logic signed [DATA_WIDTH:0]     xs;
    logic signed [DATA_WIDTH:0]     ys;
    logic signed [2*DATA_WIDTH+1:0] p;
    xs = (SIGNED != 0) ? $signed({x[DATA_WIDTH-1], x}) : $signed({1'b0, x});
    ys = (SIGNED != 0) ? $signed({y[DATA_WIDTH-1], y}) : $signed({1'b0, y});
    p  = xs * ys;
    return ACC_WIDTH'(p);
  endfunction

  // Skewed edge injection, neighbour forwarding and per-PE products
  always_comb begin
    int idx;
    idx   = 0;
    a_bus = '{default: '0};
    b_bus = '{default: '0};
    prod  = '{default: '0};
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        a_bus[i][j+1] = a_reg[i][j];
        b_bus[i+1][j] = b_reg[i][j];
      end
    end
    for (int i = 0; i < N; i++) begin
      idx = int'(k) - i;
      if (state == FEED && idx >= 0 && idx < N) begin
        a_bus[i][0] = a_lat[(i*N + idx)*DATA_WIDTH +: DATA_WIDTH];
        b_bus[0][i] = b_lat[(idx*N + i)*DATA_WIDTH +: DATA_WIDTH];
      end else begin
        a_bus[i][0] = '0;
        b_bus[0][i] = '0;
      end
    end
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        prod[i][j] = mul(a_bus[i][j], b_bus[i][j]);
      end
    end
  end

  // Sequencer and PE array state
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      k        <= '0;
      a_lat    <= '0;
      b_lat    <= '0;
      c_reg    <= '0;
      busy_reg <= 1'b0;
      done_reg <= 1'b0;
      for (int i = 0; i < N; i++) begin
        for (int j = 0; j < N; j++) begin
          a_reg[i][j] <= '0;
          b_reg[i][j] <= '0;
          acc[i][j]   <= '0;
        end
      end
    end else begin
      case (state)
        IDLE: begin
          done_reg <= 1'b0;
          if (bus.start) begin
            a_lat    <= bus.A;
            b_lat    <= bus.B;
            k        <= '0;
            busy_reg <= 1'b1;
            state    <= FEED;
            for (int i = 0; i < N; i++) begin
              for (int j = 0; j < N; j++) begin
                a_reg[i][j] <= '0;
                b_reg[i][j] <= '0;
                acc[i][j]   <= bus.acc_en ? c_reg[(i*N + j)*ACC_WIDTH +: ACC_WIDTH] : '0;
              end
            end
          end
        end
        FEED: begin
          for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
              a_reg[i][j] <= a_bus[i][j];
              b_reg[i][j] <= b_bus[i][j];
              acc[i][j]   <= acc[i][j] + prod[i][j];
            end
          end
          if (k == KW'(LAST)) begin
            state <= DRAIN;
          end else begin
            k <= k + 1'b1;
          end
        end
        DRAIN: begin
          for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
              c_reg[(i*N + j)*ACC_WIDTH +: ACC_WIDTH] <= acc[i][j];
            end
          end
          busy_reg <= 1'b0;
          done_reg <= 1'b1;
          state    <= DONE;
        end
        DONE: begin
          done_reg <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          busy_reg <= 1'b0;
          done_reg <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

  assign bus.C    = c_reg;
  assign bus.busy = busy_reg;
  assign bus.done = done_reg;

endmodule

// File: tb/tb_systolic_mm_nxn.sv
// Directed bench for systolic_mm_nxn: unsigned 2x2, signed 2x2 and 4x4 instances.
module tb_systolic_mm_nxn;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_pass   = 0;

  always #5 clk = ~clk;

  systolic_mm_nxn_if #(.DATA_WIDTH(8), .N(2), .ACC_WIDTH(24)) if2 ();
  systolic_mm_nxn_if #(.DATA_WIDTH(8), .N(2), .ACC_WIDTH(24)) ifs ();
  systolic_mm_nxn_if #(.DATA_WIDTH(8), .N(4), .ACC_WIDTH(24)) if4 ();

  systolic_mm_nxn #(.DATA_WIDTH(8), .N(2), .ACC_WIDTH(24), .SIGNED(0))
    dut2 (.clk(clk), .rst(rst), .bus(if2.slave));
  systolic_mm_nxn #(.DATA_WIDTH(8), .N(2), .ACC_WIDTH(24), .SIGNED(1))
    duts (.clk(clk), .rst(rst), .bus(ifs.slave));
  systolic_mm_nxn #(.DATA_WIDTH(8), .N(4), .ACC_WIDTH(24), .SIGNED(0))
    dut4 (.clk(clk), .rst(rst), .bus(if4.slave));

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
  endtask

  function automatic logic busy_of(input int sel);
    case (sel)
      0:       return if2.busy;
      1:       return ifs.busy;
      default: return if4.busy;
    endcase
  endfunction

  function automatic logic done_of(input int sel);
    case (sel)
      0:       return if2.done;
      1:       return ifs.done;
      default: return if4.done;
    endcase
  endfunction

  function automatic logic [31:0] el(input int sel, input int r, input int c);
    case (sel)
      0:       return {8'h00, if2.C[(r*2 + c)*24 +: 24]};
      1:       return {8'h00, ifs.C[(r*2 + c)*24 +: 24]};
      default: return {8'h00, if4.C[(r*4 + c)*24 +: 24]};
    endcase
  endfunction

  function automatic logic [31:0] s24(input int v);
    logic [23:0] t;
    t = v[23:0];
    return {8'h00, t};
  endfunction

  function automatic logic [31:0] mat2(input int m00, input int m01, input int m10, input int m11);
    logic [31:0] r;
    r[7:0]   = m00[7:0];
    r[15:8]  = m01[7:0];
    r[23:16] = m10[7:0];
    r[31:24] = m11[7:0];
    return r;
  endfunction

  task automatic set_start(input int sel, input logic v, input logic ae);
    case (sel)
      0:       begin if2.start = v; if2.acc_en = ae; end
      1:       begin ifs.start = v; ifs.acc_en = ae; end
      default: begin if4.start = v; if4.acc_en = ae; end
    endcase
  endtask

  // One-cycle start pulse, then watch busy/done for a bounded window
  task automatic run(input int sel, input logic ae, input int exp_lat, input string tag);
    int busy_n;
    int done_n;
    int lat;
    set_start(sel, 1'b1, ae);
    @(posedge clk); #1;
    set_start(sel, 1'b0, 1'b0);
    busy_n = busy_of(sel) ? 1 : 0;
    done_n = 0;
    lat    = -1;
    for (int e = 1; e <= 16; e++) begin
      @(posedge clk); #1;
      if (busy_of(sel)) busy_n++;
      if (done_of(sel)) begin
        done_n++;
        if (lat < 0) lat = e;
      end
    end
    check_val({tag, "_done_cnt"}, done_n, 32'd1);
    check_val({tag, "_busy_cyc"}, busy_n, exp_lat);
    check_val({tag, "_latency"}, lat, exp_lat);
  endtask

  task automatic check_c2(input int sel, input string tag,
                          input int e00, input int e01, input int e10, input int e11);
    check_val({tag, "_c00"}, el(sel, 0, 0), s24(e00));
    check_val({tag, "_c01"}, el(sel, 0, 1), s24(e01));
    check_val({tag, "_c10"}, el(sel, 1, 0), s24(e10));
    check_val({tag, "_c11"}, el(sel, 1, 1), s24(e11));
  endtask

  initial begin
    int done_n;
    rst = 1'b0;
    set_start(0, 1'b0, 1'b0);
    set_start(1, 1'b0, 1'b0);
    set_start(2, 1'b0, 1'b0);
    if2.A = '0; if2.B = '0;
    ifs.A = '0; ifs.B = '0;
    if4.A = '0; if4.B = '0;
    #12;
    check_val("reset_busy", {31'b0, if2.busy}, 32'd0);
    check_val("reset_done", {31'b0, if2.done}, 32'd0);
    check_val("reset_c", {31'b0, |if2.C}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;

    // Plain product, then accumulate onto it, then full-scale operands
    if2.A = mat2(1, 2, 3, 4);
    if2.B = mat2(5, 6, 7, 8);
    run(0, 1'b0, 5, "run1");
    check_c2(0, "run1", 19, 22, 43, 50);
    run(0, 1'b1, 5, "accum");
    check_c2(0, "accum", 38, 44, 86, 100);
    if2.A = mat2(255, 255, 255, 255);
    if2.B = mat2(255, 255, 255, 255);
    run(0, 1'b0, 5, "max");
    check_c2(0, "max", 130050, 130050, 130050, 130050);

    ifs.A = mat2(-1, 2, 3, -4);
    ifs.B = mat2(-128, 0, 0, -128);
    run(1, 1'b0, 5, "signed");
    check_c2(1, "signed", 128, -256, -384, 512);

    // A second start during FEED must be dropped
    if2.A = mat2(1, 2, 3, 4);
    if2.B = mat2(5, 6, 7, 8);
    set_start(0, 1'b1, 1'b0);
    @(posedge clk); #1;
    set_start(0, 1'b0, 1'b0);
    done_n = 0;
    for (int e = 1; e <= 16; e++) begin
      @(posedge clk); #1;
      if (e == 2) begin
        if2.A = mat2(9, 9, 9, 9);
        set_start(0, 1'b1, 1'b0);
      end
      if (e == 3) set_start(0, 1'b0, 1'b0);
      if (if2.done) done_n++;
    end
    check_val("ignore_done_cnt", done_n, 32'd1);
    check_c2(0, "ignore", 19, 22, 43, 50);

    // Asynchronous reset mid-FEED, away from any clock edge
    set_start(0, 1'b1, 1'b0);
    @(posedge clk); #1;
    set_start(0, 1'b0, 1'b0);
    @(posedge clk); #1;
    #2;
    rst = 1'b0;
    #1;
    check_val("midrst_c", {31'b0, |if2.C}, 32'd0);
    check_val("midrst_busy", {31'b0, if2.busy}, 32'd0);
    check_val("midrst_done", {31'b0, if2.done}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    if2.A = mat2(2, 0, 1, 3);
    if2.B = mat2(1, 1, 2, 5);
    run(0, 1'b1, 5, "post_rst");
    check_c2(0, "post_rst", 2, 2, 7, 16);

    // 4x4: identity times 1..16 returns B
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if4.A[(r*4 + c)*8 +: 8] = (r == c) ? 8'd1 : 8'd0;
        if4.B[(r*4 + c)*8 +: 8] = 8'(r*4 + c + 1);
      end
    end
    check_val("n4_idle_busy", {31'b0, if4.busy}, 32'd0);
    run(2, 1'b0, 11, "n4");
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        check_val($sformatf("n4_c%0d%0d", r, c), el(2, r, c), 32'(r*4 + c + 1));
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
